fetch_pc_sequencer: RTL and testbench

- Front end of the core. Owns the architectural fetch PC and issues word fetches to instruction memory over a req/ack handshake.
- Buffers returned instructions for decode.
- Consumes the redirect outputs of the execute stage: the valid/pc/jump triple produced by branch and jump units, plus trap redirects.
- On a redirect it discards stale work and produces the registered flush pulse that execute units take as input.

---
 rtl/fetch_pc_sequencer_pkg.sv | 19 +
 rtl/fetch_pc_sequencer_buffer.sv | 51 +++++
 rtl/fetch_pc_sequencer.sv | 115 +++++++++++
 tb/tb_fetch_pc_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pc_sequencer_pkg.sv
// Shared fetch front-end types: FSM encoding, machine word sizes and the
// buffered {pc, instr} entry.
package fetch_pc_sequencer_pkg;

   localparam int XLEN        = 32;
   localparam int INSTR_BYTES = 4;

   typedef enum logic [1:0] {
      FETCH_IDLE    = 2'd0,
      FETCH_REQ     = 2'd1,
      FETCH_DISCARD = 2'd2
   } fetch_state_e;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_pc_sequencer_buffer.sv
// Circular instruction buffer between fetch and decode. Pointers carry one
// extra wrap bit so full and empty are distinguishable without a counter.
module fetch_buffer
   import fetch_pc_sequencer_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetch_entry_t             push_entry,
   input  logic                     pop,
   input  logic                     clear,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output fetch_entry_t             head
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
   localparam logic [AW:0] WRAP_BIT = {1'b1, {AW{1'b0}}};

   logic [AW:0]  wptr;
   logic [AW:0]  rptr;
   fetch_entry_t mem [DEPTH];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push)
            wptr <= wptr + PTR_ONE;
         if (pop && !empty)
            rptr <= rptr + PTR_ONE;
      end
   end

   // Storage is data only; the pointers alone decide what is valid.
   always_ff @(posedge clk) begin
      if (push && !clear)
         mem[wptr[AW-1:0]] <= push_entry;
   end

   assign empty = (wptr == rptr);
   assign full  = ((wptr ^ rptr) == WRAP_BIT);
   assign count = wptr - rptr;
   assign head  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/fetch_pc_sequencer.sv
// Fetch front end: owns the fetch PC, issues single-outstanding word fetches,
// buffers returned instructions and turns execute/trap redirects into a flush.
module fetch_pc_sequencer
   import fetch_pc_sequencer_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
   parameter int              BUF_DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             exec_valid,
   input  logic             exec_jump_pc,
   input  logic [XLEN-1:0]  exec_pc,
   input  logic             trap_valid,
   input  logic [XLEN-1:0]  trap_pc,
   output logic             imem_req,
   output logic [XLEN-1:0]  imem_addr,
   input  logic             imem_ack,
   input  logic [XLEN-1:0]  imem_data,
   output logic             fetch_valid,
   output logic [XLEN-1:0]  fetch_instr,
   output logic [XLEN-1:0]  fetch_pc,
   input  logic             decode_ready,
   output logic             flush
);

   localparam logic [1:0] IDLE    = FETCH_IDLE;
   localparam logic [1:0] REQ     = FETCH_REQ;
   localparam logic [1:0] DISCARD = FETCH_DISCARD;
   localparam int         PTR_W   = $clog2(BUF_DEPTH) + 1;

   logic [1:0]       state;
   logic [XLEN-1:0]  pc;
   logic             flush_r;

   logic             redirect;
   logic [XLEN-1:0]  target;
   logic             buf_push;
   logic             buf_pop;
   logic             buf_full;
   logic             buf_empty;
   logic [PTR_W-1:0] buf_count;
   logic             room_after_push;
   fetch_entry_t     push_entry;
   fetch_entry_t     head;

   // Trap redirects outrank execute jumps.
   assign redirect = trap_valid || (exec_valid && exec_jump_pc);
   assign target   = trap_valid ? trap_pc : exec_pc;

   assign buf_push   = (state == REQ) && imem_ack && !redirect;
   assign buf_pop    = fetch_valid && decode_ready;
   assign push_entry = '{pc: pc, instr: imem_data};

   // After pushing one entry there is still room if occupancy was below
   // DEPTH-1, or if decode takes the head in the same cycle.
   assign room_after_push = (buf_count < PTR_W'(BUF_DEPTH - 1)) || buf_pop;

   fetch_buffer #(
      .DEPTH (BUF_DEPTH)
   ) u_fetch_buffer (
      .clk        (clk),
      .reset      (reset),
      .push       (buf_push),
      .push_entry (push_entry),
      .pop        (buf_pop),
      .clear      (redirect),
      .full       (buf_full),
      .empty      (buf_empty),
      .count      (buf_count),
      .head       (head)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         pc      <= RESET_PC;
         flush_r <= 1'b0;
      end else begin
         flush_r <= redirect;

         if (redirect)
            pc <= target;
         else if (buf_push)
            pc <= pc + XLEN'(INSTR_BYTES);

         case (state)
            IDLE: begin
               if (!redirect && !buf_full)
                  state <= REQ;
            end
            REQ: begin
               if (redirect)
                  state <= imem_ack ? IDLE : DISCARD;
               else if (imem_ack)
                  state <= room_after_push ? REQ : IDLE;
            end
            DISCARD: begin
               // The stale beat has arrived; a coincident redirect only moves pc.
               if (imem_ack)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign imem_req    = (state == REQ);
   assign imem_addr   = pc;
   assign flush       = flush_r;
   assign fetch_valid = !buf_empty && !flush_r;
   assign fetch_instr = fetch_valid ? head.instr : '0;
   assign fetch_pc    = fetch_valid ? head.pc    : '0;

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Scoreboard bench for fetch_pc_sequencer: a responder models instruction
// memory, a monitor checks every decode handshake against queued expectations.
module tb_fetch_pc_sequencer;

   typedef struct {
      logic [31:0] addr;
      int          lat;
   } req_t;

   logic        clk = 1'b0;
   logic        reset;
   logic        exec_valid, exec_jump_pc, trap_valid;
   logic [31:0] exec_pc, trap_pc;
   logic        imem_req, imem_ack;
   logic [31:0] imem_addr, imem_data;
   logic        fetch_valid, decode_ready, flush;
   logic [31:0] fetch_instr, fetch_pc;

   int          checks = 0;
   int          failures = 0;
   req_t        exp_req[$];
   logic [31:0] exp_fetch[$];
   int          exp_flush = 0;
   int          act_flush = 0;
   int          cap_cnt = 0;
   logic        pending = 1'b0;
   int          cnt = 0;
   logic [31:0] cap_addr = '0;

   fetch_pc_sequencer #(
      .RESET_PC  (32'h0000_0000),
      .BUF_DEPTH (2)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .exec_valid   (exec_valid),
      .exec_jump_pc (exec_jump_pc),
      .exec_pc      (exec_pc),
      .trap_valid   (trap_valid),
      .trap_pc      (trap_pc),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ack     (imem_ack),
      .imem_data    (imem_data),
      .fetch_valid  (fetch_valid),
      .fetch_instr  (fetch_instr),
      .fetch_pc     (fetch_pc),
      .decode_ready (decode_ready),
      .flush        (flush)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] instr_of(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
      end
   endtask

   // Memory model: accepts one request when an expectation is queued and
   // answers after the queued latency.
   initial begin
      imem_ack  = 1'b0;
      imem_data = '0;
      forever begin
         @(posedge clk); #1;
         imem_ack = 1'b0;
         if (pending) begin
            if (imem_req)
               chk("addr_stable", imem_addr, cap_addr);
            if (cnt <= 1) begin
               imem_ack  = 1'b1;
               imem_data = instr_of(cap_addr);
               pending   = 1'b0;
            end else
               cnt--;
         end else if (imem_req && exp_req.size() > 0) begin
            req_t r;
            r = exp_req.pop_front();
            chk("req_addr", imem_addr, r.addr);
            cap_addr = imem_addr;
            cnt      = r.lat;
            pending  = 1'b1;
            cap_cnt++;
         end
      end
   end

   // Decode-side monitor.
   initial begin
      forever begin
         @(negedge clk);
         if (!reset) begin
            if (flush) begin
               act_flush++;
               chk("valid_in_flush", {31'b0, fetch_valid}, 32'h0);
            end
            if (fetch_valid && decode_ready) begin
               if (exp_fetch.size() == 0) begin
                  failures++;
                  checks++;
                  $display("FAIL unexpected_fetch pc=0x%08h instr=0x%08h", fetch_pc, fetch_instr);
               end else begin
                  logic [31:0] e;
                  e = exp_fetch.pop_front();
                  chk("fetch_pc", fetch_pc, e);
                  chk("fetch_instr", fetch_instr, instr_of(e));
               end
            end
         end
      end
   end

   task automatic check_reset_vals();
      chk("rst_imem_req", {31'b0, imem_req}, 32'h0);
      chk("rst_imem_addr", imem_addr, 32'h0);
      chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'h0);
      chk("rst_fetch_instr", fetch_instr, 32'h0);
      chk("rst_fetch_pc", fetch_pc, 32'h0);
      chk("rst_flush", {31'b0, flush}, 32'h0);
   endtask

   task automatic reset_assert();
      reset = 1'b1;
      exec_valid = 1'b0; exec_jump_pc = 1'b0; trap_valid = 1'b0;
      pending = 1'b0; cap_cnt = 0; act_flush = 0; exp_flush = 0;
      exp_req.delete(); exp_fetch.delete();
      @(posedge clk); #3;
      check_reset_vals();
   endtask

   task automatic reset_release();
      @(posedge clk); #2;
      reset = 1'b0;
      @(posedge clk); #3;
      chk("first_req", {31'b0, imem_req}, 32'h1);
   endtask

   task automatic wait_cap(input int n);
      int t = 0;
      while (cap_cnt < n && t < 200) begin
         @(posedge clk); #2;
         t++;
      end
      if (cap_cnt < n)
         chk("cap_timeout", cap_cnt, n);
   endtask

   task automatic wait_done();
      int t = 0;
      while ((exp_fetch.size() != 0 || exp_req.size() != 0) && t < 300) begin
         @(posedge clk); #2;
         t++;
      end
      repeat (4) @(posedge clk);
      #2;
      chk("left_fetch", exp_fetch.size(), 0);
      chk("left_req", exp_req.size(), 0);
      chk("flush_count", act_flush, exp_flush);
   endtask

   task automatic redirect(input logic tv, input logic [31:0] tpc,
                           input logic ej, input logic [31:0] epc);
      trap_valid = tv; trap_pc = tpc;
      exec_valid = 1'b1; exec_jump_pc = ej; exec_pc = epc;
      if (tv || ej)
         exp_flush++;
      @(posedge clk); #2;
      trap_valid = 1'b0; exec_valid = 1'b0; exec_jump_pc = 1'b0;
   endtask

   task automatic run_redirect(input logic tv, input logic [31:0] tpc,
                               input logic ej, input logic [31:0] epc,
                               input logic [31:0] tgt, input int n);
      reset_assert();
      decode_ready = 1'b1;
      exp_req.push_back('{32'h0, 1});
      for (int i = 0; i < n; i++) begin
         exp_req.push_back('{tgt + 32'(4 * i), 1});
         exp_fetch.push_back(tgt + 32'(4 * i));
      end
      reset_release();
      wait_cap(1);
      redirect(tv, tpc, ej, epc);
      wait_done();
   endtask

   initial begin
      reset = 1'b1; decode_ready = 1'b1;
      exec_valid = 1'b0; exec_jump_pc = 1'b0; exec_pc = '0;
      trap_valid = 1'b0; trap_pc = '0;

      // Sequential fetch with a non-jumping execute result held high.
      reset_assert();
      for (int i = 0; i < 3; i++) begin
         exp_req.push_back('{32'(4 * i), 1});
         exp_fetch.push_back(32'(4 * i));
      end
      reset_release();
      exec_valid = 1'b1; exec_jump_pc = 1'b0; exec_pc = 32'h0000_0999;
      wait_done();
      exec_valid = 1'b0;

      // Decode stall: two entries fill the buffer, then drain and resume.
      reset_assert();
      decode_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         exp_req.push_back('{32'(4 * i), 1});
         exp_fetch.push_back(32'(4 * i));
      end
      reset_release();
      repeat (6) @(posedge clk);
      #3;
      chk("stall_req", {31'b0, imem_req}, 32'h0);
      chk("stall_valid", {31'b0, fetch_valid}, 32'h1);
      chk("stall_head_pc", fetch_pc, 32'h0);
      chk("stall_caps", cap_cnt, 2);
      decode_ready = 1'b1;
      wait_done();

      // Redirect while the fetch of 0x8 is outstanding; its ack lands in DISCARD.
      reset_assert();
      decode_ready = 1'b1;
      exp_req.push_back('{32'h0, 1});
      exp_req.push_back('{32'h4, 1});
      exp_req.push_back('{32'h8, 3});
      exp_req.push_back('{32'h100, 1});
      exp_fetch.push_back(32'h0);
      exp_fetch.push_back(32'h4);
      exp_fetch.push_back(32'h100);
      reset_release();
      wait_cap(3);
      redirect(1'b0, 32'h0, 1'b1, 32'h100);
      wait_done();

      // Trap and execute jump together: trap target wins.
      run_redirect(1'b1, 32'h200, 1'b1, 32'h300, 32'h200, 1);
      // Top of address space wraps to zero.
      run_redirect(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 2);
      // Misaligned target carries its low bits through.
      run_redirect(1'b0, 32'h0, 1'b1, 32'h0000_0103, 32'h0000_0103, 2);

      // Redirect coinciding with the ack, then a second redirect back-to-back.
      reset_assert();
      decode_ready = 1'b1;
      exp_req.push_back('{32'h0, 1});
      exp_req.push_back('{32'h80, 1});
      exp_fetch.push_back(32'h80);
      reset_release();
      wait_cap(1);
      @(posedge clk); #2;
      redirect(1'b0, 32'h0, 1'b1, 32'h40);
      redirect(1'b0, 32'h0, 1'b1, 32'h80);
      wait_done();

      // Reset with buffered data and an outstanding request; stray ack follows.
      reset_assert();
      decode_ready = 1'b0;
      exp_req.push_back('{32'h0, 1});
      exp_req.push_back('{32'h4, 1});
      exp_req.push_back('{32'h8, 2});
      exp_fetch.push_back(32'h0);
      reset_release();
      repeat (6) @(posedge clk);
      #3;
      decode_ready = 1'b1;
      @(posedge clk); #2;
      decode_ready = 1'b0;
      wait_cap(3);
      reset = 1'b1;
      @(posedge clk); #3;
      check_reset_vals();
      exp_req.push_back('{32'h0, 1});
      exp_fetch.push_back(32'h0);
      decode_ready = 1'b1;
      @(posedge clk); #2;
      chk("stray_ack_seen", {31'b0, imem_ack}, 32'h1);
      reset = 1'b0;
      @(posedge clk); #3;
      chk("restart_req", {31'b0, imem_req}, 32'h1);
      chk("restart_addr", imem_addr, 32'h0);
      wait_done();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule
